cla_adder_32bit: RTL and testbench
==================================

Name: cla_adder_32bit

Overview:
- 32-bit carry-lookahead adder with registered outputs.
- Computes A + B + cin and produces a 32-bit sum plus carry-out.
- The datapath is a two-level lookahead tree: 4-bit CLA groups feed a group-level lookahead carry unit.
- Used as the arithmetic building block wherever a fast single-cycle add is needed. Results are registered one clock after the operands are sampled.

Parameters:
- None. Width is fixed at 32 bits, organised as 8 groups of 4 bits.

Ports:
- clk    input   1   rising-edge clock
- rst_n  input   1   reset, asynchronous, active-low
- A      input   32  operand A, unsigned/two's-complement agnostic
- B      input   32  operand B
- cin    input   1   carry-in to bit 0
- sum    output  32  registered (A + B + cin) mod 2^32
- cout   output  1   registered carry-out of bit 31

Behaviour:
- Clocking and reset:
  - One clock (clk) and one reset (rst_n).
  - Reset is asynchronous and active-low.
  - While rst_n = 0: sum = 32'h0 and cout = 0, forced immediately with no clock edge required.
  - The first result after reset release is produced at the first rising clk edge with rst_n = 1.
- Latency and throughput:
  - Latency is 1 cycle. At each rising clk edge with rst_n = 1, {cout, sum} <= A + B + cin, using A, B, cin as sampled at that edge.
  - Throughput is one addition per cycle.
  - There is no handshake: the registers update on every edge.
- Bit level:
  - g[i] = A[i] & B[i]
  - p[i] = A[i] ^ B[i]
  - sum[i] = p[i] ^ c[i]
  - c[0] = cin
- Group level (4-bit CLA block k, bits 4k..4k+3):
  - Internal carries are fully expanded lookahead from the group carry-in. There is no ripple inside the group.
  - Group outputs: PG = p3&p2&p1&p0 and GG = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0.
- Lookahead carry unit:
  - Computes the group carry-ins C[k], k = 1..7, and cout = C[8] from {PG[k], GG[k]} and cin, as a two-level lookahead tree.
  - First level: two 4-group lookahead units (groups 0-3 and 4-7), each producing super-group P/G.
  - Second level: combines the two super-groups with cin.
  - No carry may ripple serially through more than one 4-bit group.
- Arithmetic:
  - Result is modulo 2^32. cout is the 33rd bit.
  - No overflow flag is produced. Signed interpretation is left to the user.
- Boundary cases:
  - All-ones + 0 + cin=1 wraps to 0 with cout = 1.
  - All-ones + all-ones + 1 = all-ones with cout = 1.
  - A = B = 0, cin = 0 gives 0, cout = 0.
- Input timing: operand changes between clock edges have no effect on outputs until the next edge.
- Reset during operation: asserting rst_n mid-cycle clears outputs immediately. Operands present at the first edge after release are added normally.
- Implementation constraints:
  - Combinational core and output register in one module, or the core as submodules (4-bit CLA group, lookahead unit).
  - Must be synthesizable.
  - No use of the behavioural "+" operator in the core.

Test Plan:
- Reset: hold rst_n = 0, apply A=5, B=7, toggle clk -> sum = 0, cout = 0 throughout. Release reset -> sum = 12 after the next edge.
- Basic add: A=128, B=64, cin=1 -> one edge later sum = 193 (0x000000C1), cout = 0. The value must not appear before the edge.
- Full carry chain: A=32'hFFFFFFFF, B=0, cin=1 -> sum = 0, cout = 1. Also A=B=32'hFFFFFFFF, cin=1 -> sum = 32'hFFFFFFFF, cout = 1.
- Group boundary propagation: A=32'h0000FFFF, B=1, cin=0 -> sum = 32'h00010000, cout = 0. A=32'h7FFFFFFF, B=1, cin=0 -> sum = 32'h80000000, cout = 0.
- Async reset mid-stream: with outputs at a nonzero value, drop rst_n between edges -> sum/cout go to 0 before the next clk edge. Back-to-back operands on consecutive edges produce results on consecutive cycles.
- Random regression: 10,000 random {A, B, cin} -> compare {cout, sum} one cycle later against a reference A + B + cin model. Zero mismatches required.

Source files
------------

// File: rtl/cla_adder_32bit.sv
// 32-bit two-level carry-lookahead adder with registered sum and carry-out.
// Bits are grouped in eight 4-bit CLA blocks. Two 4-group lookahead units form
// super-groups that are combined with cin, so no carry ripples serially through
// more than one group.
module cla_adder_32bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [7:0]  w_gg;
    logic [7:0]  w_pg;
    logic [8:0]  w_gc;   // group carry-ins; w_gc[8] is the carry-out
    logic [31:0] w_c;    // per-bit carry-ins
    logic [31:0] w_sum;
    logic [1:0]  w_sg;
    logic [1:0]  w_sp;
    logic [3:0]  w_la_lo;
    logic [3:0]  w_la_hi;
    logic [31:0] r_sum;
    logic        r_cout;

    // Fully expanded 4-wide lookahead: returns {c3, c2, c1, c0} from ci.
    // Shared by the bit-level groups and the group-level lookahead units.
    function automatic logic [3:0] f_carry4(input logic [3:0] g, input logic [3:0] p,
                                            input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Block generate over four positions.
    function automatic logic f_gen4(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Bit-level generate/propagate.
    always_comb begin
        w_g = A & B;
        w_p = A ^ B;
    end

    // Per-group block propagate/generate.
    always_comb begin
        w_gg = '0;
        w_pg = '0;
        for (int k = 0; k < 8; k++) begin
            w_pg[k] = &w_p[4*k +: 4];
            w_gg[k] = f_gen4(w_g[4*k +: 4], w_p[4*k +: 4]);
        end
    end

    // Two-level lookahead: super-group P/G, then group carries from cin.
    always_comb begin
        w_sp[0] = &w_pg[3:0];
        w_sp[1] = &w_pg[7:4];
        w_sg[0] = f_gen4(w_gg[3:0], w_pg[3:0]);
        w_sg[1] = f_gen4(w_gg[7:4], w_pg[7:4]);
        w_gc    = '0;
        w_gc[0] = cin;
        w_gc[4] = w_sg[0] | (w_sp[0] & cin);
        w_gc[8] = w_sg[1] | (w_sp[1] & w_sg[0]) | (w_sp[1] & w_sp[0] & cin);
        w_la_lo = f_carry4(w_gg[3:0], w_pg[3:0], cin);
        w_la_hi = f_carry4(w_gg[7:4], w_pg[7:4], w_gg[3] | (w_pg[3] & w_la_lo[3]));
        w_la_hi = f_carry4(w_gg[7:4], w_pg[7:4], w_sg[0] | (w_sp[0] & cin));
        w_gc[3:1] = w_la_lo[3:1];
        w_gc[7:5] = w_la_hi[3:1];
    end

    // Bit carries inside each group and the sum.
    always_comb begin
        w_c = '0;
        for (int k = 0; k < 8; k++) begin
            w_c[4*k +: 4] = f_carry4(w_g[4*k +: 4], w_p[4*k +: 4], w_gc[k]);
        end
        w_sum = w_p ^ w_c;
    end

    // Output register, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= 32'h0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_gc[8];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_cla_adder_32bit.sv
// Self-checking bench for cla_adder_32bit: directed vector table, hand-written
// reset/timing sequences and a randomized regression against A + B + cin.
module tb_cla_adder_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[14];

    cla_adder_32bit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h",
                     name, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
        A   = a;
        B   = b;
        cin = ci;
    endtask

    initial begin
        vec_t v;
        logic [32:0] ref_q;
        logic [31:0] ra, rb;
        logic        rc;

        vecs[0]  = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[3]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
        vecs[4]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
        vecs[5]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[6]  = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0};
        vecs[7]  = '{32'h0000000F, 32'h00000000, 1'b1, 32'h00000010, 1'b0};
        vecs[8]  = '{32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0};
        vecs[9]  = '{32'h0FFFFFFF, 32'h00000000, 1'b1, 32'h10000000, 1'b0};
        vecs[10] = '{32'hFFFFFFFE, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0};
        vecs[11] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 1'b1};
        vecs[12] = '{32'hDEADBEEF, 32'h00000001, 1'b0, 32'hDEADBEF0, 1'b0};
        vecs[13] = '{32'h0000FFFF, 32'hFFFF0000, 1'b1, 32'h00000000, 1'b1};

        n_checks = 0;
        n_fails  = 0;

        // Reset held low: outputs zero with no edge, and across edges.
        rst_n = 1'b0;
        drive(32'd5, 32'd7, 1'b0);
        #1;
        check("reset_no_edge", {cout, sum}, 33'h0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_held", {cout, sum}, 33'h0);
        end

        // Release between edges; first edge produces 5 + 7.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge", {cout, sum}, 33'h0);
        @(posedge clk);
        #1;
        check("first_after_reset", {cout, sum}, {1'b0, 32'd12});

        // Basic add must not appear before the edge.
        @(negedge clk);
        drive(32'd128, 32'd64, 1'b1);
        #1;
        check("basic_before_edge", {cout, sum}, {1'b0, 32'd12});
        @(posedge clk);
        #1;
        check("basic_add", {cout, sum}, {1'b0, 32'h000000C1});

        // Operand change mid-cycle does not affect outputs.
        @(negedge clk);
        drive(32'hFFFFFFFF, 32'h00000001, 1'b0);
        #2;
        drive(32'h00000010, 32'h00000020, 1'b0);
        #1;
        check("mid_cycle_hold", {cout, sum}, {1'b0, 32'h000000C1});
        @(posedge clk);
        #1;
        check("mid_cycle_last_wins", {cout, sum}, {1'b0, 32'h00000030});

        // Directed table, back-to-back on consecutive edges.
        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            @(negedge clk);
            drive(v.a, v.b, v.ci);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {cout, sum}, {v.exp_cout, v.exp_sum});
        end

        // Async reset mid-stream from a nonzero output.
        @(negedge clk);
        drive(32'h12345678, 32'h11111111, 1'b1);
        @(posedge clk);
        #1;
        check("pre_async", {cout, sum}, {1'b0, 32'h2345678A});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", {cout, sum}, 33'h0);
        @(posedge clk);
        #1;
        check("async_held", {cout, sum}, 33'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'hF0000000, 32'h20000000, 1'b0);
        @(posedge clk);
        #1;
        check("after_async_release", {cout, sum}, {1'b1, 32'h10000000});

        // Randomized regression against a reference sum.
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1, 0));
            ref_q = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
            @(negedge clk);
            drive(ra, rb, rc);
            @(posedge clk);
            #1;
            check("random", {cout, sum}, ref_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
